div_unit: RTL and testbench

//   Multi-cycle iterative divider for the RV32M DIV/DIVU/REM/REMU group.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit.
// The master side issues op/a/b and accepts results; the slave side is the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface : div_unit_if

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One shift/subtract per clock; divide-by-zero and signed overflow are answered
// immediately with the RISC-V defined values.
// Optional build macro DIV_EARLY_TERM_EN: requests with |a| < |b| also finish
// in one cycle (quotient 0, remainder a). Results are identical either way.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ret_rem;
  logic [WIDTH-1:0] r_result;

  // Request decode: operand magnitudes and the one-cycle special cases.
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_early;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic             w_accept;
  logic             w_last;

  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b  = w_b_neg ? -bus.b : bus.b;
  assign w_b_zero = (bus.b == '0);
  assign w_ovf    = w_signed & (bus.a == MIN_NEG) & (bus.b == '1);
`ifdef DIV_EARLY_TERM_EN
  assign w_early  = ~w_b_zero & ~w_ovf & (w_abs_a < w_abs_b);
`else
  assign w_early  = 1'b0;
`endif
  assign w_special = w_b_zero | w_ovf | w_early;
  assign w_accept  = bus.in_valid & (r_state == IDLE);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Pick the immediate answer for a special-case request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_spec_res = bus.op[1] ? bus.a : '0;
    if (w_b_zero) begin
      w_spec_res = bus.op[1] ? bus.a : '1;
    end else if (w_ovf) begin
      w_spec_res = bus.op[1] ? '0 : bus.a;
    end
  end

  // One restoring step: the borrow of a WIDTH+1 bit subtract decides rem >= |b|.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_sub     = {1'b0, w_shift[WIDTH-1:0]} - {1'b0, r_div};
  assign w_ge      = w_shift[WIDTH] | ~w_sub[WIDTH];
  assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_next = w_special ? DONE : BUSY;
      BUSY: if (w_last)       w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in BUSY, apply sign fixup entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ret_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_rem     <= '0;
        r_quo     <= w_abs_a;
        r_div     <= w_abs_b;
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_ret_rem <= bus.op[1];
        if (w_special) r_result <= w_spec_res;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        if (w_last) r_result <= r_ret_rem ? w_r_fix : w_q_fix;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.result    = r_result;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M vectors, stall/hold and
// mid-operation reset scenarios, then randomized requests. A driver pushes the
// expected result and latency into a scoreboard; a monitor pops and compares
// whenever out_valid rises. Latency is counted in clock edges after the accept
// edge: 0 means out_valid is already up in the first cycle after accept.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    sa  = a;
    sbv = b;
    if (b == '0) return op[1] ? a : '1;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == MINV && b == '1) return op[1] ? '0 : a;
    return op[1] ? W'(sa % sbv) : W'(sa / sbv);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint ma;
    longint mb;
    ma = op[0] ? longint'({{(64-W){1'b0}}, a}) : longint'($signed(a));
    mb = op[0] ? longint'({{(64-W){1'b0}}, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == '0) return 0;
    if (!op[0] && a == MINV && b == '1) return 0;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 0;
`endif
    return W;
  endfunction

  // Driver: wait for in_ready, present one request for one edge, log expectation.
  task automatic issue(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check({name, " in_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    e.res  = res;
    e.lat  = exp_lat(op, a, b);
    e.acc  = cyc + 1;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Monitor: compare on each rising out_valid.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid === 1'b1 && !prev_ov) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, " result"}, 64'(bus.result), 64'(e.res));
        check({e.name, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    prev_ov = (bus.out_valid === 1'b1);
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.in_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check({name, " drain_timeout"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    int           highs;

    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    // Directed vectors with fixed expected values.
    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
    issue("div_m9_0", 2'b00, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF);
    issue("rem_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7);
    issue("divu_3_9", 2'b01, 32'd3, 32'd9, 32'd0);
    issue("remu_3_9", 2'b11, 32'd3, 32'd9, 32'd3);
    issue("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    drain("directed");

    // Hold in DONE with out_ready low; competing requests must be ignored.
    bus.out_ready = 1'b0;
    issue("hold_divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold reached_done", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd50;
    bus.b = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold result", 64'(bus.result), 64'd14);
      check("hold out_valid", 64'(bus.out_valid), 64'd1);
      check("hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", 64'(bus.out_valid), 64'd0);
    check("release in_ready", 64'(bus.in_ready), 64'd1);
    check("release busy", 64'(bus.busy), 64'd0);
    bus.in_valid = 1'b0;
    drain("hold");

    // Reset on the 10th iteration edge discards the request.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_rst busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst result", 64'(bus.result), 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst busy", 64'(bus.busy), 64'd0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) highs++;
    end
    check("midrst no_result", 64'(highs), 64'd0);

    // Randomized requests, biased toward the corner cases.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = MINV; b = '1; end
        2: b = W'($urandom_range(1, 15));
        3: begin a = W'($urandom_range(0, 20)); b = W'($urandom_range(1, 40)); end
        4: b = {$urandom_range(0, 1) == 1, 31'($urandom_range(1, 1000))};
        default: ;
      endcase
      issue($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end
    drain("random");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_unit
